// File: rtl/zx_mem_mapper_pkg.sv
// Shared constants and helpers for the Spectrum memory/IO mapper:
// paging port decode, paging register field positions and fixed bank numbers.
package zx_mem_mapper_pkg;

  localparam logic [15:0] PAGE_PORT_MASK  = 16'h8002;
  localparam logic [15:0] PAGE_PORT_MATCH = 16'h0000;

  localparam int PG_W       = 6;
  localparam int PG_RAM_LSB = 0;
  localparam int PG_SCREEN  = 3;
  localparam int PG_ROM     = 4;
  localparam int PG_LOCK    = 5;

  localparam logic [2:0] BANK_SCREEN = 3'd5;
  localparam logic [2:0] BANK_SHADOW = 3'd7;
  localparam logic [2:0] BANK_MID    = 3'd2;

  // 16K CPU address windows, selected by cpu_addr[15:14]
  typedef enum logic [1:0] {
    REGION_ROM = 2'd0,
    REGION_LOW = 2'd1,
    REGION_MID = 2'd2,
    REGION_TOP = 2'd3
  } region_e;

  function automatic logic is_page_port(input logic [15:0] addr);
    return (addr & PAGE_PORT_MASK) == PAGE_PORT_MATCH;
  endfunction

endpackage

// File: rtl/zx_mem_mapper_if.sv
// CPU-side bus between tv80n and the mapper: address, data, strobes in;
// chip selects, write enable and physical ROM/RAM addresses out.
interface zx_mem_mapper_if #(
  parameter int RAM_AW = 17,
  parameter int ROM_AW = 15
);
  logic [15:0]       cpu_addr;
  logic [7:0]        cpu_dout;
  logic              n_mreq;
  logic              n_iorq;
  logic              n_rd;
  logic              n_wr;
  logic              n_romCS;
  logic              n_ramCS;
  logic              n_kbdCS;
  logic [ROM_AW-1:0] rom_addr;
  logic [RAM_AW-1:0] ram_addr;
  logic              ram_we;

  modport master (
    output cpu_addr, cpu_dout, n_mreq, n_iorq, n_rd, n_wr,
    input  n_romCS, n_ramCS, n_kbdCS, rom_addr, ram_addr, ram_we
  );

  modport slave (
    input  cpu_addr, cpu_dout, n_mreq, n_iorq, n_rd, n_wr,
    output n_romCS, n_ramCS, n_kbdCS, rom_addr, ram_addr, ram_we
  );
endinterface

// File: rtl/zx_mem_mapper_clk_div.sv
// CPU clock divider with normal/turbo ratio; the ratio is only re-latched on
// counter wrap so a turbo toggle can never shorten a cpu_clk phase.
module zx_clk_div #(
  parameter int CLK_DIV   = 5,
  parameter int TURBO_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic turbo,
  output logic cpu_clk,
  output logic cpu_clk_en
);

  localparam int MAX_DIV = (CLK_DIV > TURBO_DIV) ? CLK_DIV : TURBO_DIV;
  localparam int CW      = $clog2(MAX_DIV + 1);

  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] NORM_D  = CW'(CLK_DIV);
  localparam logic [CW-1:0] TURBO_D = CW'(TURBO_DIV);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] div_r;
  logic [CW-1:0] half_s;
  logic [CW-1:0] last_s;
  logic          high_s;

  assign half_s = div_r >> 1;
  assign last_s = div_r - ONE;
  assign high_s = (cnt_r >= half_s);

  // Period counter, ratio latch and registered clock/enable outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r      <= '0;
      div_r      <= NORM_D;
      cpu_clk    <= 1'b0;
      cpu_clk_en <= 1'b0;
    end else begin
      if (cnt_r == last_s) begin
        cnt_r <= '0;
        div_r <= turbo ? TURBO_D : NORM_D;
      end else begin
        cnt_r <= cnt_r + ONE;
      end
      cpu_clk    <= high_s;
      cpu_clk_en <= high_s & ~cpu_clk;
    end
  end

endmodule

// File: rtl/zx_mem_mapper.sv
// Spectrum memory/IO mapper: 128K-style paging via port 0x7FFD with lock bit,
// physical ROM/RAM address generation and turbo-capable CPU clock.
module zx_mem_mapper
  import zx_mem_mapper_pkg::*;
#(
  parameter int  PAGING    = 1,
  parameter int  RAM_BANKS = 8,
  parameter int  ROM_BANKS = 2,
  parameter int  CLK_DIV   = 5,
  parameter int  TURBO_DIV = 2,
  localparam int RAM_BW    = (RAM_BANKS > 1) ? $clog2(RAM_BANKS) : 1,
  localparam int ROM_BW    = (ROM_BANKS > 1) ? $clog2(ROM_BANKS) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              turbo,
  output logic              cpu_clk,
  output logic              cpu_clk_en,
  zx_mem_mapper_if.slave    bus,
  output logic [RAM_BW-1:0] vid_bank,
  output logic [PG_W-1:0]   page_reg
);

  localparam logic PAGING_EN = (PAGING != 0);

  logic [PG_W-1:0]   page_r;
  logic              pwr_s;
  logic              pwr_r;
  region_e           region_s;
  logic [2:0]        bank3_s;
  logic [2:0]        vid3_s;
  logic              rom_sel_s;
  logic [RAM_BW-1:0] ram_bank_s;
  logic [ROM_BW-1:0] rom_bank_s;
  logic              mem_s;
  logic              rom_cs_s;
  logic              ram_cs_s;
  logic              unused_s;

  zx_clk_div #(
    .CLK_DIV   (CLK_DIV),
    .TURBO_DIV (TURBO_DIV)
  ) u_clk_div (
    .clk        (clk),
    .reset_n    (reset_n),
    .turbo      (turbo),
    .cpu_clk    (cpu_clk),
    .cpu_clk_en (cpu_clk_en)
  );

  assign pwr_s = ~bus.n_iorq & ~bus.n_wr & is_page_port(bus.cpu_addr);

  // Paging register: one commit per IO cycle on the rising edge of pwr.
  // pwr_r resets high so a strobe still held across reset cannot commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwr_r  <= 1'b1;
      page_r <= '0;
    end else begin
      pwr_r <= pwr_s;
      if (PAGING_EN && pwr_s && !pwr_r && !page_r[PG_LOCK]) begin
        page_r <= bus.cpu_dout[PG_W-1:0];
      end else begin
        page_r <= page_r;
      end
    end
  end

  // Bank selection for the 16K window addressed by the CPU
  always_comb begin
    region_s  = region_e'(bus.cpu_addr[15:14]);
    bank3_s   = 3'd0;
    vid3_s    = 3'd0;
    rom_sel_s = 1'b0;
    if (PAGING_EN) begin
      rom_sel_s = page_r[PG_ROM];
      vid3_s    = page_r[PG_SCREEN] ? BANK_SHADOW : BANK_SCREEN;
      case (region_s)
        REGION_LOW: bank3_s = BANK_SCREEN;
        REGION_MID: bank3_s = BANK_MID;
        REGION_TOP: bank3_s = page_r[PG_RAM_LSB +: 3];
        default:    bank3_s = 3'd0;
      endcase
    end else begin
      case (region_s)
        REGION_LOW: bank3_s = 3'd0;
        REGION_MID: bank3_s = 3'd1;
        REGION_TOP: bank3_s = 3'd2;
        default:    bank3_s = 3'd0;
      endcase
    end
  end

  assign ram_bank_s = RAM_BW'(bank3_s);
  assign rom_bank_s = ROM_BW'(rom_sel_s);

  assign mem_s    = ~bus.n_mreq;
  assign rom_cs_s = mem_s & (region_s == REGION_ROM);
  assign ram_cs_s = mem_s & (region_s != REGION_ROM);

  assign bus.n_romCS  = ~rom_cs_s;
  assign bus.n_ramCS  = ~ram_cs_s;
  assign bus.n_kbdCS  = ~(~bus.n_iorq & ~bus.n_rd & ~bus.cpu_addr[0]);
  assign bus.ram_we   = ram_cs_s & ~bus.n_wr;
  assign bus.rom_addr = {rom_bank_s, bus.cpu_addr[13:0]};
  assign bus.ram_addr = {ram_bank_s, bus.cpu_addr[13:0]};

  assign vid_bank = RAM_BW'(vid3_s);
  assign page_reg = page_r;

  // cpu_dout[7:6] have no meaning in the paging register
  assign unused_s = &{1'b0, bus.cpu_dout[7:6]};

endmodule

// File: tb/tb_zx_mem_mapper.sv
// Scoreboard bench: random CPU accesses drive a paged and a fixed-map mapper;
// expectations come from a window/bank model, clock periods are measured.
module tb_zx_mem_mapper;

  localparam int RAM_AW = 17;
  localparam int ROM_AW = 15;
  localparam int K_MRD = 0, K_MWR = 1, K_IRD = 2, K_IWR = 3;

  typedef struct packed {
    logic        n_rom;
    logic        n_ram;
    logic        n_kbd;
    logic        we;
    logic [14:0] rom_a;
    logic [16:0] ram_a;
    logic        chk_ram;
    logic [2:0]  vid;
    logic [5:0]  pg;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic turbo = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_dout = 8'h00;
  logic n_mreq = 1'b1, n_iorq = 1'b1, n_rd = 1'b1, n_wr = 1'b1;

  logic       cpu_clk_p, cpu_clk_en_p, cpu_clk_f, cpu_clk_en_f;
  logic [2:0] vid_p, vid_f;
  logic [5:0] page_p, page_f;

  int checks = 0;
  int errors = 0;
  exp_t q_p[$];
  exp_t q_f[$];
  exp_t ep, ef;
  logic [5:0] page_m = 6'd0;

  int per_q[$];
  int hi_q[$];
  int cyc = 0, last_fall = -1, high_len = 0;
  logic prev_p = 1'b0, prev_f = 1'b0;

  always #5 clk = ~clk;

  zx_mem_mapper_if #(.RAM_AW(RAM_AW), .ROM_AW(ROM_AW)) bus_p ();
  zx_mem_mapper_if #(.RAM_AW(RAM_AW), .ROM_AW(ROM_AW)) bus_f ();

  assign bus_p.cpu_addr = cpu_addr;
  assign bus_p.cpu_dout = cpu_dout;
  assign bus_p.n_mreq   = n_mreq;
  assign bus_p.n_iorq   = n_iorq;
  assign bus_p.n_rd     = n_rd;
  assign bus_p.n_wr     = n_wr;
  assign bus_f.cpu_addr = cpu_addr;
  assign bus_f.cpu_dout = cpu_dout;
  assign bus_f.n_mreq   = n_mreq;
  assign bus_f.n_iorq   = n_iorq;
  assign bus_f.n_rd     = n_rd;
  assign bus_f.n_wr     = n_wr;

  zx_mem_mapper #(.PAGING(1), .RAM_BANKS(8), .ROM_BANKS(2), .CLK_DIV(5), .TURBO_DIV(2)) dut_p (
    .clk(clk), .reset_n(reset_n), .turbo(turbo), .cpu_clk(cpu_clk_p), .cpu_clk_en(cpu_clk_en_p),
    .bus(bus_p), .vid_bank(vid_p), .page_reg(page_p));

  zx_mem_mapper #(.PAGING(0), .RAM_BANKS(8), .ROM_BANKS(2), .CLK_DIV(5), .TURBO_DIV(2)) dut_f (
    .clk(clk), .reset_n(reset_n), .turbo(turbo), .cpu_clk(cpu_clk_f), .cpu_clk_en(cpu_clk_en_f),
    .bus(bus_f), .vid_bank(vid_f), .page_reg(page_f));

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference map: 16K windows, bank lists per mode, arithmetic addresses
  function automatic exp_t predict(input logic [15:0] a, input logic [5:0] pg, input bit paging, input int kind);
    exp_t e;
    int region, rom_bank, ofs;
    int ram_map [4];
    region = int'(a) / 16384;
    ofs    = int'(a) % 16384;
    if (paging) begin
      rom_bank = int'(pg[4]);
      ram_map[0] = 0; ram_map[1] = 5; ram_map[2] = 2; ram_map[3] = int'(pg[2:0]);
      e.vid = pg[3] ? 3'd7 : 3'd5;
    end else begin
      rom_bank = 0;
      ram_map[0] = 0; ram_map[1] = 0; ram_map[2] = 1; ram_map[3] = 2;
      e.vid = 3'd0;
    end
    e.rom_a   = 15'(rom_bank * 16384 + ofs);
    e.ram_a   = 17'(ram_map[region] * 16384 + ofs);
    e.chk_ram = (region != 0);
    e.n_rom   = !(kind < 2 && region == 0);
    e.n_ram   = !(kind < 2 && region != 0);
    e.n_kbd   = !(kind == K_IRD && (int'(a) % 2) == 0);
    e.we      = (kind == K_MWR && region != 0);
    e.pg      = pg;
    return e;
  endfunction

  task automatic cmp_bus(input string tag, input exp_t e, input logic [5:0] pg, input logic [2:0] vid,
                         input logic n_rom, input logic n_ram, input logic n_kbd, input logic we,
                         input logic [14:0] rom_a, input logic [16:0] ram_a);
    cmp({tag, ".n_romCS"}, n_rom, e.n_rom);
    cmp({tag, ".n_ramCS"}, n_ram, e.n_ram);
    cmp({tag, ".n_kbdCS"}, n_kbd, e.n_kbd);
    cmp({tag, ".ram_we"}, we, e.we);
    cmp({tag, ".rom_addr"}, rom_a, e.rom_a);
    if (e.chk_ram) cmp({tag, ".ram_addr"}, ram_a, e.ram_a);
    cmp({tag, ".vid_bank"}, vid, e.vid);
    cmp({tag, ".page_reg"}, pg, e.pg);
  endtask

  // Scoreboard monitor: every clk with an active strobe consumes one expectation per DUT
  always @(negedge clk) begin
    if (reset_n && (!n_mreq || !n_iorq)) begin
      if (q_p.size() == 0 || q_f.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_underflow: access seen at 0x%0h with no expectation queued", cpu_addr);
      end else begin
        ep = q_p.pop_front();
        ef = q_f.pop_front();
        cmp_bus("paged", ep, page_p, vid_p, bus_p.n_romCS, bus_p.n_ramCS, bus_p.n_kbdCS,
                bus_p.ram_we, bus_p.rom_addr, bus_p.ram_addr);
        cmp_bus("fixed", ef, page_f, vid_f, bus_f.n_romCS, bus_f.n_ramCS, bus_f.n_kbdCS,
                bus_f.ram_we, bus_f.rom_addr, bus_f.ram_addr);
      end
    end
  end

  // Clock monitor: cpu_clk_en must mark each rise; record fall-to-fall periods and high time
  always @(negedge clk) begin
    if (!reset_n) begin
      last_fall = -1; high_len = 0; prev_p = 1'b0; prev_f = 1'b0;
    end else begin
      cyc++;
      cmp("clk_en_p", cpu_clk_en_p, cpu_clk_p && !prev_p);
      cmp("clk_en_f", cpu_clk_en_f, cpu_clk_f && !prev_f);
      if (cpu_clk_p) high_len++;
      if (prev_p && !cpu_clk_p) begin
        if (last_fall >= 0) begin
          per_q.push_back(cyc - last_fall);
          hi_q.push_back(high_len);
        end
        last_fall = cyc;
        high_len = 0;
      end
      prev_p = cpu_clk_p;
      prev_f = cpu_clk_f;
    end
  end

  task automatic do_access(input int kind, input logic [15:0] a, input logic [7:0] d, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      cpu_addr = a;
      cpu_dout = d;
      n_mreq = !(kind == K_MRD || kind == K_MWR);
      n_iorq = !(kind == K_IRD || kind == K_IWR);
      n_rd   = !(kind == K_MRD || kind == K_IRD);
      n_wr   = !(kind == K_MWR || kind == K_IWR);
      q_p.push_back(predict(a, page_m, 1'b1, kind));
      q_f.push_back(predict(a, 6'd0, 1'b0, kind));
      if (c == 0 && kind == K_IWR && (a & 16'h8002) == 16'h0000 && !page_m[5]) page_m = d[5:0];
    end
    @(posedge clk); #1;
    n_mreq = 1'b1; n_iorq = 1'b1; n_rd = 1'b1; n_wr = 1'b1;
  endtask

  task automatic wait_periods(input int n);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (per_q.size() >= n) return;
    end
    cmp("period_timeout", per_q.size(), n);
  endtask

  task automatic wait_fall();
    int sz;
    sz = per_q.size();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (per_q.size() > sz) return;
    end
    cmp("fall_timeout", per_q.size(), sz + 1);
  endtask

  task automatic check_seq(input string name, input int d0, input int d1, input int n);
    int d;
    for (int i = 0; i < n; i++) begin
      d = (i == 0) ? d0 : d1;
      cmp($sformatf("%s.period%0d", name, i), per_q[i], d);
      cmp($sformatf("%s.high%0d", name, i), hi_q[i], d - d / 2);
    end
  endtask

  initial begin
    #2;
    cmp("reset.cpu_clk", cpu_clk_p, 1'b0);
    cmp("reset.cpu_clk_en", cpu_clk_en_p, 1'b0);
    cmp("reset.page_reg", page_p, 6'h00);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Normal ratio, then a turbo switch mid-period and back
    wait_periods(3);
    check_seq("normal", 5, 5, 3);
    wait_fall();
    @(negedge clk); #1;
    per_q.delete(); hi_q.delete();
    turbo = 1'b1;
    wait_periods(4);
    check_seq("turbo_on", 5, 2, 4);
    wait_fall();
    per_q.delete(); hi_q.delete();
    turbo = 1'b0;
    wait_periods(3);
    check_seq("turbo_off", 2, 5, 3);

    // Directed paging scenarios
    do_access(K_IWR, 16'h7FFD, 8'h13, 10);
    cmp("page_13", page_p, 6'h13);
    do_access(K_MRD, 16'hC123, 8'h00, 1);
    do_access(K_MRD, 16'h0005, 8'h00, 1);
    cmp("vid_normal", vid_p, 3'd5);
    do_access(K_IWR, 16'h7FFD, 8'h28, 2);
    do_access(K_IWR, 16'h7FFD, 8'h07, 2);
    cmp("page_locked", page_p, 6'h28);
    cmp("vid_shadow", vid_p, 3'd7);
    cmp("fixed_page", page_f, 6'h00);
    do_access(K_MRD, 16'hC000, 8'h00, 1);
    do_access(K_MRD, 16'h4000, 8'h00, 1);
    do_access(K_IRD, 16'h00FE, 8'h00, 1);
    do_access(K_MWR, 16'h8000, 8'h55, 1);
    do_access(K_MWR, 16'h1000, 8'h55, 1);

    // Reset clears the lock
    @(posedge clk); #2;
    reset_n = 1'b0;
    page_m = 6'd0;
    #1;
    cmp("rst2.page_reg", page_p, 6'h00);
    cmp("rst2.cpu_clk", cpu_clk_p, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    do_access(K_IWR, 16'h7FFD, 8'h07, 3);
    cmp("page_after_reset", page_p, 6'h07);

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      int kind;
      logic [15:0] a;
      logic [7:0] d;
      kind = int'($urandom_range(3, 0));
      a = 16'($urandom);
      d = 8'($urandom);
      if ($urandom_range(7, 0) != 0) d[5] = 1'b0;
      if (kind == K_IWR && $urandom_range(1, 0) == 0) a = 16'h7FFD;
      do_access(kind, a, d, int'($urandom_range(3, 1)));
    end

    cmp("sb_drain_p", q_p.size(), 0);
    cmp("sb_drain_f", q_f.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
